// File: rtl/rover_command_sequencer_pkg.sv
// Package for the rover command sequencer.
// Contents:
//   - The sequencer state type.
//   - Default timing constants derived from the clock rate.
//   - A helper that recognises the all-zero no-op command.
`include "rover_defs.vh"

package rover_command_sequencer_pkg;

  localparam int SEQ_CMD_W = `CMD_W;
  localparam int SEQ_CLK_HZ = `CLK_HZ;

  // 100 ms settle gap and 5 s watchdog at the system clock rate.
  localparam int DEF_SETTLE_CYCLES  = SEQ_CLK_HZ / 10;
  localparam int DEF_TIMEOUT_CYCLES = SEQ_CLK_HZ * 5;

  typedef enum logic [1:0] {
    ST_IDLE   = `SEQ_IDLE,
    ST_ISSUE  = `SEQ_ISSUE,
    ST_RUN    = `SEQ_RUN,
    ST_SETTLE = `SEQ_SETTLE
  } seq_state_t;

  // A command with zero angle and zero distance asks for no motion.
  function automatic logic cmd_is_noop(input logic [SEQ_CMD_W-1:0] cmd);
    return (cmd[`ANGLE_MSB:`ANGLE_LSB] == '0) && (cmd[`DIST_MSB:`DIST_LSB] == '0);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with show-ahead output.
// dout always shows the head entry, so a pop consumes the value already visible.
// Ports:
//   clock, reset  clock and synchronous active-high reset
//   push, din     write din at the tail (a push is legal when full if pop is also high)
//   pop           drop the head entry (caller guarantees !empty)
//   flush         empty the queue; wins over push/pop in the same cycle
//   dout          head entry
//   count         entries held (0..DEPTH)
//   full, empty   count == DEPTH / count == 0
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  // Storage needs no reset: nothing is read until count says it was written.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/rover_defs.vh
// Shared definitions for the rover command path: command width, command
// field positions, sequencer state encodings and the system clock rate.
`ifndef ROVER_DEFS_VH
`define ROVER_DEFS_VH

`define CMD_W      12
`define ANGLE_MSB  11
`define ANGLE_LSB  7
`define DIST_MSB   6
`define DIST_LSB   0

`define SEQ_IDLE   2'd0
`define SEQ_ISSUE  2'd1
`define SEQ_RUN    2'd2
`define SEQ_SETTLE 2'd3

`define CLK_HZ     27_000_000

`endif

// File: rtl/rover_command_sequencer.sv
// Rover command sequencer.
// Buffers motion commands from the IR decoder and issues them one at a time
// to the motor block, waiting for motor_done before the next one. It also:
//   - inserts a settle gap after every completed move;
//   - guards each move with a watchdog;
//   - offers an abort that flushes everything.
// Ports:
//   clock, reset     clock and synchronous active-high reset
//   cmd_valid/cmd_in one-cycle strobe with a new {angle, distance} command
//   abort            level; flush queue, stop motors, return to idle
//   motor_done       one-cycle pulse: current move finished
//   motor_cmd        command presented to the motor block (registered)
//   motor_cmd_ready  one-cycle strobe: start the move in motor_cmd
//   motor_stop       one-cycle strobe: motor block must drop both motor lines
//   queue_count      entries queued; queue_full when it equals DEPTH
//   dropped          one-cycle pulse: a command was rejected because the queue was full
//   timeout_err      sticky watchdog flag, cleared by reset or abort
//   busy             sequencer is not idle
module rover_command_sequencer
  import rover_command_sequencer_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int CMD_W          = SEQ_CMD_W,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [CMD_W-1:0]       cmd_in,
  input  logic                   abort,
  input  logic                   motor_done,
  output logic [CMD_W-1:0]       motor_cmd,
  output logic                   motor_cmd_ready,
  output logic                   motor_stop,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   queue_full,
  output logic                   dropped,
  output logic                   timeout_err,
  output logic                   busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

  seq_state_t       state_q;
  logic [WD_W-1:0]  wd_q;
  logic [ST_W-1:0]  settle_q;
  logic             done_pend_q;
  logic [CMD_W-1:0] motor_cmd_q;
  logic             motor_cmd_ready_q;
  logic             motor_stop_q;
  logic             dropped_q;
  logic             timeout_err_q;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_dout;
  logic             run_done;
  logic             timeout_fire;

  // A motor_done seen during ISSUE is held in done_pend_q and honoured in RUN.
  assign run_done = motor_done || done_pend_q;

  // Completion wins over a watchdog expiry landing on the same cycle.
  assign timeout_fire = (state_q == ST_RUN) && !run_done &&
                        (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  assign fifo_pop   = (state_q == ST_IDLE) && !abort && !fifo_empty;
  assign fifo_push  = cmd_valid && !abort && (!fifo_full || fifo_pop);
  // A command arriving on the watchdog cycle is lost with the rest of the queue.
  assign fifo_flush = abort || timeout_fire;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (cmd_in),
    .dout  (fifo_dout),
    .count (queue_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      wd_q              <= '0;
      settle_q          <= '0;
      done_pend_q       <= 1'b0;
      motor_cmd_q       <= '0;
      motor_cmd_ready_q <= 1'b0;
      motor_stop_q      <= 1'b0;
      dropped_q         <= 1'b0;
      timeout_err_q     <= 1'b0;
    end else begin
      motor_cmd_ready_q <= 1'b0;
      motor_stop_q      <= 1'b0;
      // Abort swallows cmd_valid silently, so it never reports a drop.
      dropped_q         <= cmd_valid && !abort && fifo_full && !fifo_pop;

      if (abort) begin
        state_q       <= ST_IDLE;
        motor_stop_q  <= (state_q == ST_ISSUE) || (state_q == ST_RUN);
        timeout_err_q <= 1'b0;
        done_pend_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // No-op heads are popped and discarded without leaving IDLE.
            if (fifo_pop && !cmd_is_noop(fifo_dout)) begin
              motor_cmd_q       <= fifo_dout;
              motor_cmd_ready_q <= 1'b1;
              state_q           <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            wd_q        <= '0;
            done_pend_q <= motor_done;
            state_q     <= ST_RUN;
          end
          ST_RUN: begin
            if (run_done) begin
              done_pend_q <= 1'b0;
              settle_q    <= '0;
              state_q     <= ST_SETTLE;
            end else if (timeout_fire) begin
              timeout_err_q <= 1'b1;
              motor_stop_q  <= 1'b1;
              state_q       <= ST_IDLE;
            end else begin
              wd_q <= wd_q + WD_W'(1);
            end
          end
          ST_SETTLE: begin
            if (settle_q == ST_W'(SETTLE_CYCLES - 1)) begin
              state_q <= ST_IDLE;
            end else begin
              settle_q <= settle_q + ST_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign motor_cmd       = motor_cmd_q;
  assign motor_cmd_ready = motor_cmd_ready_q;
  assign motor_stop      = motor_stop_q;
  assign queue_full      = fifo_full;
  assign dropped         = dropped_q;
  assign timeout_err     = timeout_err_q;
  assign busy            = (state_q != ST_IDLE);

endmodule
